// File: rtl/priority_decoder_pulse_if.sv
`default_nettype none
// ============================================================================
//  Module   : priority_decoder_pulse_if
//  Purpose  : Handshake and output bundle for priority_decoder_pulse. Carries
//             the encoded line index (valid/ready) into the decoder and the
//             one-hot strobe vector plus status flags back out.
//  Ports    : in_valid, in_ready, in_code[IN_W], in_none   (request side)
//             out_onehot[OUT_W], out_valid, busy, err      (strobe side)
//  Modports : master - producer of codes / consumer of strobes
//             slave  - the decoder itself
//  Revision : 1.0  initial release
// ============================================================================
interface priority_decoder_pulse_if #(
    parameter int OUT_W = 8
);
    // Code width follows the line count; it is not independently adjustable.
    localparam int c_IN_W = $clog2(OUT_W);

    logic              in_valid;
    logic              in_ready;
    logic [c_IN_W-1:0] in_code;
    logic              in_none;
    logic [OUT_W-1:0]  out_onehot;
    logic              out_valid;
    logic              busy;
    logic              err;

    modport master (
        output in_valid, in_code, in_none,
        input  in_ready, out_onehot, out_valid, busy, err
    );

    modport slave (
        input  in_valid, in_code, in_none,
        output in_ready, out_onehot, out_valid, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/priority_decoder_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : priority_decoder_pulse
//  Purpose  : Re-expands an encoded request index into a registered one-hot
//             strobe held for PULSE_LEN cycles, followed by GAP_LEN forced
//             idle cycles. A "none" flag yields an all-zero strobe that is
//             still flagged valid, keeping "no request" distinct from line 0.
//  Ports    : clk        - clock, all state updates on posedge
//             rst        - synchronous active-high reset
//             bus.slave  - in_valid/in_ready/in_code/in_none handshake,
//                          out_onehot/out_valid/busy/err outputs
//  Params   : OUT_W (>=2), PULSE_LEN (>=1), GAP_LEN (>=0)
//  Macro    : DEC_HOLD_EN - when defined, out_onehot keeps the last decoded
//             value through GAP and IDLE until the next accept or reset.
//  Revision : 1.0  initial release
// ============================================================================
module priority_decoder_pulse #(
    parameter int OUT_W     = 8,
    parameter int PULSE_LEN = 1,
    parameter int GAP_LEN   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    priority_decoder_pulse_if.slave bus
);

    localparam int c_IN_W    = $clog2(OUT_W);
    localparam int c_CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    // Loaded values never exceed c_CNT_MAX-1, so clog2 bits suffice.
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_PULSE_LOAD = c_CNT_W'(PULSE_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD   = c_CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [c_IN_W:0]    c_OUT_W_EXT  = (c_IN_W + 1)'(OUT_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [OUT_W-1:0]   r_onehot;
    logic [OUT_W-1:0]   w_onehot_nxt;
    logic [OUT_W-1:0]   w_decoded;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_ready;
    logic               w_accept;
    logic               w_cnt_zero;
    logic               w_code_oob;

    assign w_cnt_zero = (r_cnt == '0);

    // Back-to-back acceptance is only possible on the last DRIVE cycle and
    // only when there is no gap to serve afterwards.
    assign w_ready  = !rst && ((r_state == S_IDLE) ||
                               ((r_state == S_DRIVE) && w_cnt_zero && (GAP_LEN == 0)));
    assign w_accept = bus.in_valid && w_ready;

    // Codes past the last line are legal input when OUT_W is not a power of
    // two; they decode to nothing and raise err.
    assign w_code_oob = ({1'b0, bus.in_code} >= c_OUT_W_EXT);

    always_comb begin
        w_decoded = '0;
        if (!bus.in_none && !w_code_oob) begin
            w_decoded[bus.in_code] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_onehot_nxt = r_onehot;
        w_err_nxt    = 1'b0;

        if (w_accept) begin
            w_state_nxt  = S_DRIVE;
            w_cnt_nxt    = c_PULSE_LOAD;
            w_onehot_nxt = w_decoded;
            w_err_nxt    = !bus.in_none && w_code_oob;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                S_DRIVE: begin
                    if (!w_cnt_zero) begin
                        w_cnt_nxt = r_cnt - c_CNT_W'(1);
                    end else if (GAP_LEN > 0) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = c_GAP_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_GAP: begin
                    if (!w_cnt_zero) begin
                        w_cnt_nxt = r_cnt - c_CNT_W'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        w_valid_nxt = (w_state_nxt == S_DRIVE);

`ifdef DEC_HOLD_EN
        // Lines hold their last decoded value between pulses.
`else
        // Pure pulse: lines are only ever set while the strobe is valid.
        if (!w_valid_nxt) begin
            w_onehot_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_onehot <= w_onehot_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out_onehot = r_onehot;
    assign bus.out_valid  = r_valid;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_priority_decoder_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : tb_priority_decoder_pulse
//  Purpose  : Self-checking bench for priority_decoder_pulse. Three decoder
//             instances with different shapes share clock and reset:
//               dut0 OUT_W=8 PULSE_LEN=1 GAP_LEN=0 (full-throughput case)
//               dut1 OUT_W=8 PULSE_LEN=3 GAP_LEN=2 (pulse plus gap)
//               dut2 OUT_W=6 PULSE_LEN=2 GAP_LEN=1 (out-of-range codes)
//             Each is compared every cycle against a reference that tracks
//             "cycles left in the current transaction" per instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_priority_decoder_pulse;

`ifdef DEC_HOLD_EN
    localparam bit c_HOLD = 1'b1;
`else
    localparam bit c_HOLD = 1'b0;
`endif
    localparam int c_CYCLES = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       drv_valid  [3];
    logic [2:0] drv_code   [3];
    logic       drv_none   [3];
    logic       got_ready  [3];
    logic [7:0] got_onehot [3];
    logic       got_valid  [3];
    logic       got_busy   [3];
    logic       got_err    [3];

    int n_checks = 0;
    int n_errors = 0;

    priority_decoder_pulse_if #(.OUT_W(8)) bus0 ();
    priority_decoder_pulse_if #(.OUT_W(8)) bus1 ();
    priority_decoder_pulse_if #(.OUT_W(6)) bus2 ();

    priority_decoder_pulse #(.OUT_W(8), .PULSE_LEN(1), .GAP_LEN(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );
    priority_decoder_pulse #(.OUT_W(8), .PULSE_LEN(3), .GAP_LEN(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );
    priority_decoder_pulse #(.OUT_W(6), .PULSE_LEN(2), .GAP_LEN(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus0.in_valid = drv_valid[0];
    assign bus0.in_code  = drv_code[0];
    assign bus0.in_none  = drv_none[0];
    assign bus1.in_valid = drv_valid[1];
    assign bus1.in_code  = drv_code[1];
    assign bus1.in_none  = drv_none[1];
    assign bus2.in_valid = drv_valid[2];
    assign bus2.in_code  = drv_code[2];
    assign bus2.in_none  = drv_none[2];

    assign got_ready[0]  = bus0.in_ready;
    assign got_onehot[0] = bus0.out_onehot;
    assign got_valid[0]  = bus0.out_valid;
    assign got_busy[0]   = bus0.busy;
    assign got_err[0]    = bus0.err;
    assign got_ready[1]  = bus1.in_ready;
    assign got_onehot[1] = bus1.out_onehot;
    assign got_valid[1]  = bus1.out_valid;
    assign got_busy[1]   = bus1.busy;
    assign got_err[1]    = bus1.err;
    assign got_ready[2]  = bus2.in_ready;
    assign got_onehot[2] = {2'b00, bus2.out_onehot};
    assign got_valid[2]  = bus2.out_valid;
    assign got_busy[2]   = bus2.busy;
    assign got_err[2]    = bus2.err;

    function automatic int cfg_w(input int k);
        case (k)
            0:       return 8;
            1:       return 8;
            default: return 6;
        endcase
    endfunction

    function automatic int cfg_p(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_g(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: cycles remaining in the current transaction (pulse
    // plus gap), the line vector it decoded to and whether it was flagged.
    int         m_left [3];
    logic [7:0] m_line [3];
    logic       m_err  [3];
    logic       m_acc  [3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_left[k]    = 0;
            m_line[k]    = '0;
            m_err[k]     = 1'b0;
            m_acc[k]     = 1'b0;
            drv_valid[k] = 1'b1;
            drv_code[k]  = 3'd0;
            drv_none[k]  = 1'b0;
        end
        rst = 1'b1;

        for (int cyc = 0; cyc < c_CYCLES; cyc++) begin
            @(negedge clk);
            // Stimulus: two reset cycles with requests pending, then a
            // sequential code sweep held valid, then random traffic with
            // occasional resets landing mid-pulse or mid-gap.
            if (cyc < 2) begin
                rst = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    drv_valid[k] = 1'b1;
                    drv_code[k]  = 3'($urandom_range(0, 7));
                    drv_none[k]  = 1'b0;
                end
            end else if (cyc < 12) begin
                rst = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    drv_valid[k] = 1'b1;
                    drv_code[k]  = 3'((cyc - 2) % 8);
                    drv_none[k]  = (cyc - 2 >= 8);
                end
            end else begin
                rst = ($urandom_range(0, 59) == 0);
                for (int k = 0; k < 3; k++) begin
                    drv_valid[k] = ($urandom_range(0, 3) != 0);
                    drv_none[k]  = ($urandom_range(0, 7) == 0);
                    drv_code[k]  = drv_valid[k] ? 3'($urandom_range(0, 7)) : 3'bxxx;
                end
            end
            #1;

            for (int k = 0; k < 3; k++) begin
                logic exp_ready;
                exp_ready = !rst && ((m_left[k] == 0) || (cfg_g(k) == 0 && m_left[k] == 1));
                check_val($sformatf("dut%0d.in_ready", k), 32'(got_ready[k]), 32'(exp_ready));
                m_acc[k] = exp_ready && drv_valid[k];
            end

            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    m_left[k] = 0;
                    m_line[k] = '0;
                    m_err[k]  = 1'b0;
                end else if (m_acc[k]) begin
                    m_left[k] = cfg_p(k) + cfg_g(k);
                    if (!drv_none[k] && int'(drv_code[k]) < cfg_w(k))
                        m_line[k] = 8'(1) << drv_code[k];
                    else
                        m_line[k] = '0;
                    m_err[k] = !drv_none[k] && int'(drv_code[k]) >= cfg_w(k);
                end else begin
                    if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
                    m_err[k] = 1'b0;
                end
            end
            #1;

            for (int k = 0; k < 3; k++) begin
                logic       exp_valid;
                logic [7:0] exp_line;
                exp_valid = (m_left[k] > cfg_g(k));
                exp_line  = (exp_valid || c_HOLD) ? m_line[k] : 8'h00;
                check_val($sformatf("dut%0d.out_valid", k),  32'(got_valid[k]),  32'(exp_valid));
                check_val($sformatf("dut%0d.out_onehot", k), 32'(got_onehot[k]), 32'(exp_line));
                check_val($sformatf("dut%0d.busy", k),       32'(got_busy[k]),   32'(m_left[k] > 0));
                check_val($sformatf("dut%0d.err", k),        32'(got_err[k]),    32'(m_err[k]));
                check_val($sformatf("dut%0d.onehot_bits", k),
                          32'($countones(got_onehot[k]) <= 1), 32'(1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
